hex_scan_display: RTL

Parametrised multiplexed hex display driver for common-anode/common-cathode 7-segment banks. It scans `DIGITS` digits with a programmable dwell time, adds per-digit decimal points, per-digit blinking, optional leading-zero blanking, a load-strobed shadow register and configurable output polarity. It sits between CPU-visible display registers and the board pins, and succeeds the fixed 4-digit, one-digit-per-clock scanner.

---
 rtl/hex_scan_display_pkg.sv | 22 ++
 rtl/hex_to_seg.sv | 45 ++++
 rtl/hex_scan_display.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/hex_scan_display_pkg.sv
// Shared display definitions: segment vector type, blank pattern, bit order of
// {a..g} within a segment vector, and a counter-width helper.
package hex_scan_display_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_OFF = 7'b0000000;

   localparam int SEG_A_BIT = 6;
   localparam int SEG_B_BIT = 5;
   localparam int SEG_C_BIT = 4;
   localparam int SEG_D_BIT = 3;
   localparam int SEG_E_BIT = 2;
   localparam int SEG_F_BIT = 1;
   localparam int SEG_G_BIT = 0;

   // Bits needed to count 0..range-1, never less than one.
   function automatic int unsigned cnt_width(input int unsigned range);
      return (range <= 1) ? 1 : $clog2(range);
   endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Hex nibble to active-high 7-segment glyph, placed on the shared segment bit order.
module hex_to_seg
   import hex_scan_display_pkg::*;
(
   input  logic [3:0] nibble,
   output seg_t       seg
);

   seg_t abcdefg;

   always_comb begin
      // NOTE: assigning a default before the case keeps this purely combinational (no latch).
      abcdefg = SEG_OFF;
      case (nibble)
         4'h0: abcdefg = 7'b1111110;
         4'h1: abcdefg = 7'b0110000;
         4'h2: abcdefg = 7'b1101101;
         4'h3: abcdefg = 7'b1111001;
         4'h4: abcdefg = 7'b0110011;
         4'h5: abcdefg = 7'b1011011;
         4'h6: abcdefg = 7'b1011111;
         4'h7: abcdefg = 7'b1110000;
         4'h8: abcdefg = 7'b1111111;
         4'h9: abcdefg = 7'b1111011;
         4'hA: abcdefg = 7'b1110111;
         4'hB: abcdefg = 7'b0011111;
         4'hC: abcdefg = 7'b1001110;
         4'hD: abcdefg = 7'b0111101;
         4'hE: abcdefg = 7'b1001111;
         4'hF: abcdefg = 7'b1000111;
      endcase
   end

   always_comb begin
      seg            = SEG_OFF;
      seg[SEG_A_BIT] = abcdefg[6];
      seg[SEG_B_BIT] = abcdefg[5];
      seg[SEG_C_BIT] = abcdefg[4];
      seg[SEG_D_BIT] = abcdefg[3];
      seg[SEG_E_BIT] = abcdefg[2];
      seg[SEG_F_BIT] = abcdefg[1];
      seg[SEG_G_BIT] = abcdefg[0];
   end

endmodule

// File: rtl/hex_scan_display.sv
// Multiplexed hex display driver: shadow-latched digits scanned with a programmable dwell,
// per-digit dp and blink, leading-zero blanking, and registered polarity-adjusted pins.
module hex_scan_display
   import hex_scan_display_pkg::*;
#(
   parameter int unsigned DIGITS           = 4,
   parameter int unsigned PRESCALE         = 1024,
   parameter int unsigned BLINK_LOG2       = 6,
   parameter bit          ANODE_ACTIVE_LOW = 1'b0,
   parameter bit          SEG_ACTIVE_LOW   = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [4*DIGITS-1:0] data,
   input  logic [DIGITS-1:0]   dp,
   input  logic [DIGITS-1:0]   blink,
   input  logic                load,
   input  logic                lz_blank,
   input  logic                en,
   output logic [DIGITS-1:0]   anodes,
   output logic [6:0]          segments,
   output logic                dp_out,
   output logic                frame_tick
);

   localparam int unsigned PCNT_W = cnt_width(PRESCALE);
   localparam int unsigned IDX_W  = cnt_width(DIGITS);
   localparam int unsigned FCNT_W = (BLINK_LOG2 == 0) ? 1 : BLINK_LOG2;

   localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESCALE - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
   // With BLINK_LOG2 = 0 the frame counter stays at 0 and the phase flips every frame.
   localparam logic [FCNT_W-1:0] FCNT_LAST = (BLINK_LOG2 == 0) ? '0 : '1;

   localparam logic [DIGITS-1:0] ANODES_IDLE = {DIGITS{ANODE_ACTIVE_LOW}};
   localparam seg_t              SEG_IDLE    = {7{SEG_ACTIVE_LOW}} ^ SEG_OFF;
   localparam logic              DP_IDLE     = SEG_ACTIVE_LOW;

   logic [4*DIGITS-1:0] data_d, data_q;
   logic [DIGITS-1:0]   dp_d, dp_q;
   logic [DIGITS-1:0]   blink_d, blink_q;
   logic [PCNT_W-1:0]   pcnt_d, pcnt_q;
   logic [IDX_W-1:0]    idx_d, idx_q;
   logic [FCNT_W-1:0]   fcnt_d, fcnt_q;
   logic                bph_d, bph_q;
   logic [DIGITS-1:0]   anodes_d, anodes_q;
   seg_t                segments_d, segments_q;
   logic                dp_out_d, dp_out_q;
   logic                frame_tick_d, frame_tick_q;

   logic [3:0]          nib [DIGITS];
   logic [DIGITS-1:0]   nz_suffix;
   logic [3:0]          cur_nib;
   seg_t                glyph;
   logic [DIGITS-1:0]   onehot;
   logic                dwell_end;
   logic                frame_end;
   logic                lz_hit;
   logic                blank;

   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
      assign nib[gi] = data_q[4*gi +: 4];
   end

   // nz_suffix[i] is set when any shadow nibble from i up to the top digit is non-zero.
   always_comb begin
      logic acc;
      acc       = 1'b0;
      nz_suffix = '0;
      for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
         acc          = acc | (|nib[i]);
         nz_suffix[i] = acc;
      end
   end

   assign cur_nib   = nib[idx_q];
   assign onehot    = DIGITS'(1) << idx_q;
   assign dwell_end = (pcnt_q == PCNT_LAST);
   assign frame_end = dwell_end && (idx_q == IDX_LAST);
   assign lz_hit    = lz_blank && (idx_q != '0) && !nz_suffix[idx_q];
   assign blank     = !en || (blink_q[idx_q] && bph_q) || lz_hit;

   hex_to_seg u_glyph (
      .nibble (cur_nib),
      .seg    (glyph)
   );

   always_comb begin
      data_d  = data_q;
      dp_d    = dp_q;
      blink_d = blink_q;
      if (load) begin
         data_d  = data;
         dp_d    = dp;
         blink_d = blink;
      end

      pcnt_d = dwell_end ? '0 : pcnt_q + PCNT_W'(1);
      idx_d  = idx_q;
      if (dwell_end) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end

      fcnt_d = fcnt_q;
      bph_d  = bph_q;
      if (frame_end) begin
         fcnt_d = (fcnt_q == FCNT_LAST) ? '0 : fcnt_q + FCNT_W'(1);
         if (fcnt_q == FCNT_LAST) begin
            bph_d = ~bph_q;
         end
      end

      anodes_d   = '0;
      segments_d = SEG_OFF;
      dp_out_d   = 1'b0;
      if (!blank) begin
         anodes_d   = onehot;
         segments_d = glyph;
         dp_out_d   = dp_q[idx_q];
      end
      // Pin polarity is applied last, just ahead of the output register.
      anodes_d     = anodes_d ^ ANODES_IDLE;
      segments_d   = segments_d ^ SEG_IDLE;
      dp_out_d     = dp_out_d ^ DP_IDLE;
      frame_tick_d = frame_end;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the shadow registers are reset too, so a freshly reset display shows '0'.
         data_q       <= '0;
         dp_q         <= '0;
         blink_q      <= '0;
         pcnt_q       <= '0;
         idx_q        <= '0;
         fcnt_q       <= '0;
         bph_q        <= 1'b0;
         anodes_q     <= ANODES_IDLE;
         segments_q   <= SEG_IDLE;
         dp_out_q     <= DP_IDLE;
         frame_tick_q <= 1'b0;
      end else begin
         data_q       <= data_d;
         dp_q         <= dp_d;
         blink_q      <= blink_d;
         pcnt_q       <= pcnt_d;
         idx_q        <= idx_d;
         fcnt_q       <= fcnt_d;
         bph_q        <= bph_d;
         anodes_q     <= anodes_d;
         segments_q   <= segments_d;
         dp_out_q     <= dp_out_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign anodes     = anodes_q;
   assign segments   = segments_q;
   assign dp_out     = dp_out_q;
   assign frame_tick = frame_tick_q;

endmodule
